// File: rtl/wb_txn_monitor.sv
// Passive Wishbone classic-cycle monitor: records every terminated transaction
// into a first-word-fall-through capture FIFO, with a watchdog and sticky flags.
module wb_txn_monitor #(
    parameter int unsigned ADR_W   = 30,
    parameter int unsigned DAT_W   = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     clk48,
    input  logic                     reset,
    input  logic [ADR_W-1:0]         wb_adr,
    input  logic [DAT_W-1:0]         wb_dat_w,
    input  logic [DAT_W-1:0]         wb_dat_r,
    input  logic [DAT_W/8-1:0]       wb_sel,
    input  logic                     wb_cyc,
    input  logic                     wb_stb,
    input  logic                     wb_we,
    input  logic                     wb_ack,
    input  logic                     wb_err,
    input  logic                     rd_en,
    input  logic                     clr,
    output logic                     rd_valid,
    output logic [ADR_W-1:0]         rd_adr,
    output logic [DAT_W-1:0]         rd_data,
    output logic [DAT_W/8-1:0]       rd_sel,
    output logic                     rd_we,
    output logic [1:0]               rd_status,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [CNT_W-1:0]         txn_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow,
    output logic                     timeout_seen
);

    localparam int unsigned SEL_W = DAT_W / 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned FC_W  = PTR_W + 1;
    localparam int unsigned WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    localparam bit             WD_EN   = (TIMEOUT > 0);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    localparam logic [1:0] ST_ACK = 2'b01;
    localparam logic [1:0] ST_ERR = 2'b10;
    localparam logic [1:0] ST_TMO = 2'b11;

    logic             act;
    logic             term;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WD_W-1:0]  wd;
    logic [WD_W-1:0]  wd_nxt;
    logic             push;
    logic             tmo;
    logic [1:0]       push_status;
    logic [DAT_W-1:0] push_data;

    assign act  = wb_cyc & wb_stb;
    assign term = act & (wb_ack | wb_err);

    // Bus tracking state and watchdog
    always_ff @(posedge clk48 or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            wd    <= '0;
        end else begin
            state <= state_nxt;
            wd    <= wd_nxt;
        end
    end

    // Termination wins over watchdog expiry; wd is always zero in IDLE
    always_comb begin
        state_nxt   = state;
        wd_nxt      = wd;
        push        = 1'b0;
        tmo         = 1'b0;
        push_status = ST_ACK;
        push_data   = wb_dat_w;
        case (state)
            S_IDLE, S_WAIT: begin
                if (term) begin
                    push        = 1'b1;
                    push_status = wb_err ? ST_ERR : ST_ACK;
                    push_data   = wb_we ? wb_dat_w : wb_dat_r;
                    state_nxt   = S_IDLE;
                    wd_nxt      = '0;
                end else if (act && WD_EN && (wd == WD_LAST)) begin
                    push        = 1'b1;
                    tmo         = 1'b1;
                    push_status = ST_TMO;
                    push_data   = wb_we ? wb_dat_w : '0;
                    state_nxt   = S_HOLD;
                    wd_nxt      = '0;
                end else if (act) begin
                    state_nxt = S_WAIT;
                    wd_nxt    = wd + WD_W'(1);
                end else begin
                    state_nxt = S_IDLE;
                    wd_nxt    = '0;
                end
            end
            S_HOLD: begin
                wd_nxt = '0;
                if (!act) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                wd_nxt    = '0;
            end
        endcase
    end

    logic [ADR_W-1:0] mem_adr [DEPTH];
    logic [DAT_W-1:0] mem_dat [DEPTH];
    logic [SEL_W-1:0] mem_sel [DEPTH];
    logic             mem_we  [DEPTH];
    logic [1:0]       mem_st  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [FC_W-1:0]  count_nxt;
    logic             full;
    logic             pop;
    logic             wr_ok;
    logic             drop;

    assign full  = (fifo_count == FC_W'(DEPTH));
    assign pop   = rd_en & rd_valid;
    assign wr_ok = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_comb begin
        count_nxt = fifo_count;
        if (wr_ok && !pop) begin
            count_nxt = fifo_count + FC_W'(1);
        end else if (pop && !wr_ok) begin
            count_nxt = fifo_count - FC_W'(1);
        end
    end

    // When full with a pop, wr_ptr equals rd_ptr: the new entry lands behind the new head
    always_ff @(posedge clk48 or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_adr[i] <= '0;
                mem_dat[i] <= '0;
                mem_sel[i] <= '0;
                mem_we[i]  <= 1'b0;
                mem_st[i]  <= 2'b00;
            end
        end else if (wr_ok) begin
            mem_adr[wr_ptr] <= wb_adr;
            mem_dat[wr_ptr] <= push_data;
            mem_sel[wr_ptr] <= wb_sel;
            mem_we[wr_ptr]  <= wb_we;
            mem_st[wr_ptr]  <= push_status;
        end
    end

    always_ff @(posedge clk48 or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rd_valid   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= count_nxt;
            rd_valid   <= (count_nxt != '0);
        end
    end

    assign rd_adr    = mem_adr[rd_ptr];
    assign rd_data   = mem_dat[rd_ptr];
    assign rd_sel    = mem_sel[rd_ptr];
    assign rd_we     = mem_we[rd_ptr];
    assign rd_status = mem_st[rd_ptr];

    // Saturating counters and sticky flags; a coincident event beats clr
    always_ff @(posedge clk48 or posedge reset) begin
        if (reset) begin
            txn_count    <= '0;
            drop_count   <= '0;
            overflow     <= 1'b0;
            timeout_seen <= 1'b0;
        end else begin
            if (clr) begin
                txn_count <= push ? CNT_W'(1) : '0;
            end else if (push && (txn_count != '1)) begin
                txn_count <= txn_count + CNT_W'(1);
            end

            if (clr) begin
                drop_count <= drop ? CNT_W'(1) : '0;
            end else if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_W'(1);
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (clr) begin
                overflow <= 1'b0;
            end

            if (tmo) begin
                timeout_seen <= 1'b1;
            end else if (clr) begin
                timeout_seen <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_txn_monitor.sv
// Bench for wb_txn_monitor: table-driven transactions, scoreboard of expected
// FIFO entries, and hand-written sequences for timeout, overflow and reset.
module tb_wb_txn_monitor;

    localparam int unsigned ADR_W   = 30;
    localparam int unsigned DAT_W   = 32;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CNT_W   = 16;

    logic             clk48 = 1'b0;
    logic             reset;
    logic [ADR_W-1:0] wb_adr;
    logic [DAT_W-1:0] wb_dat_w;
    logic [DAT_W-1:0] wb_dat_r;
    logic [SEL_W-1:0] wb_sel;
    logic             wb_cyc, wb_stb, wb_we, wb_ack, wb_err;
    logic             rd_en, clr;
    logic             rd_valid;
    logic [ADR_W-1:0] rd_adr;
    logic [DAT_W-1:0] rd_data;
    logic [SEL_W-1:0] rd_sel;
    logic             rd_we;
    logic [1:0]       rd_status;
    logic [2:0]       fifo_count;
    logic [CNT_W-1:0] txn_count;
    logic [CNT_W-1:0] drop_count;
    logic             overflow;
    logic             timeout_seen;

    always #5 clk48 = ~clk48;

    wb_txn_monitor #(
        .ADR_W(ADR_W), .DAT_W(DAT_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
    ) dut (
        .clk48(clk48), .reset(reset),
        .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r), .wb_sel(wb_sel),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack), .wb_err(wb_err),
        .rd_en(rd_en), .clr(clr),
        .rd_valid(rd_valid), .rd_adr(rd_adr), .rd_data(rd_data), .rd_sel(rd_sel),
        .rd_we(rd_we), .rd_status(rd_status), .fifo_count(fifo_count),
        .txn_count(txn_count), .drop_count(drop_count),
        .overflow(overflow), .timeout_seen(timeout_seen)
    );

    typedef struct {
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] data;
        logic [SEL_W-1:0] sel;
        logic             we;
        logic [1:0]       status;
    } entry_t;

    typedef struct {
        logic [ADR_W-1:0] adr;
        logic             we;
        logic [DAT_W-1:0] dw;
        logic [DAT_W-1:0] dr;
        logic [SEL_W-1:0] sel;
        int               waits;
        logic             ack;
        logic             err;
        logic [DAT_W-1:0] exp_data;
        logic [1:0]       exp_status;
    } vec_t;

    entry_t sb[$];
    vec_t   vecs[7];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     model_count = 0;
    int     model_txn   = 0;
    int     model_drop  = 0;
    logic   model_ovf   = 1'b0;
    logic   model_to    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".fifo_count"},   64'(fifo_count),   64'(model_count));
        check({tag, ".rd_valid"},     64'(rd_valid),     64'(model_count != 0));
        check({tag, ".txn_count"},    64'(txn_count),    64'(model_txn));
        check({tag, ".drop_count"},   64'(drop_count),   64'(model_drop));
        check({tag, ".overflow"},     64'(overflow),     64'(model_ovf));
        check({tag, ".timeout_seen"}, 64'(timeout_seen), 64'(model_to));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".rd_valid"},     64'(rd_valid),     64'd0);
        check({tag, ".rd_adr"},       64'(rd_adr),       64'd0);
        check({tag, ".rd_data"},      64'(rd_data),      64'd0);
        check({tag, ".rd_sel"},       64'(rd_sel),       64'd0);
        check({tag, ".rd_we"},        64'(rd_we),        64'd0);
        check({tag, ".rd_status"},    64'(rd_status),    64'd0);
        check({tag, ".fifo_count"},   64'(fifo_count),   64'd0);
        check({tag, ".txn_count"},    64'(txn_count),    64'd0);
        check({tag, ".drop_count"},   64'(drop_count),   64'd0);
        check({tag, ".overflow"},     64'(overflow),     64'd0);
        check({tag, ".timeout_seen"}, 64'(timeout_seen), 64'd0);
    endtask

    // Model of one terminated transaction reaching the FIFO (no coincident pop)
    task automatic expect_push(input entry_t e);
        model_txn++;
        if (model_count < int'(DEPTH)) begin
            sb.push_back(e);
            model_count++;
        end else begin
            model_drop++;
            model_ovf = 1'b1;
        end
    endtask

    task automatic check_head(input string tag, input entry_t e);
        check({tag, ".rd_valid"},  64'(rd_valid),  64'd1);
        check({tag, ".rd_adr"},    64'(rd_adr),    64'(e.adr));
        check({tag, ".rd_data"},   64'(rd_data),   64'(e.data));
        check({tag, ".rd_sel"},    64'(rd_sel),    64'(e.sel));
        check({tag, ".rd_we"},     64'(rd_we),     64'(e.we));
        check({tag, ".rd_status"}, 64'(rd_status), 64'(e.status));
    endtask

    task automatic drain(input string tag);
        entry_t e;
        while (sb.size() > 0) begin
            @(negedge clk48);
            e = sb.pop_front();
            check_head(tag, e);
            model_count--;
            rd_en = 1'b1;
        end
        @(negedge clk48);
        rd_en = 1'b0;
        check({tag, ".empty"}, 64'(fifo_count), 64'd0);
    endtask

    task automatic bus_txn(input logic [ADR_W-1:0] a, input logic we, input logic [DAT_W-1:0] dw,
                           input logic [DAT_W-1:0] dr, input logic [SEL_W-1:0] s,
                           input int waits, input logic ack_v, input logic err_v);
        @(negedge clk48);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_adr = a; wb_we = we;
        wb_dat_w = dw; wb_dat_r = dr; wb_sel = s; wb_ack = 1'b0; wb_err = 1'b0;
        repeat (waits) @(negedge clk48);
        wb_ack = ack_v; wb_err = err_v;
        @(negedge clk48);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
    endtask

    task automatic do_clr(input string tag);
        @(negedge clk48);
        clr = 1'b1;
        @(negedge clk48);
        clr = 1'b0;
        model_txn = 0; model_drop = 0; model_ovf = 1'b0; model_to = 1'b0;
        check_state(tag);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got still running, expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        entry_t e;
        vecs[0] = '{30'h100, 1'b1, 32'hDEADBEEF, 32'h0, 4'hF, 2, 1'b1, 1'b0, 32'hDEADBEEF, 2'b01};
        vecs[1] = '{30'h004, 1'b0, 32'h11111111, 32'h12345678, 4'hF, 0, 1'b1, 1'b0, 32'h12345678, 2'b01};
        vecs[2] = '{30'h2A0, 1'b1, 32'hA5A5A5A5, 32'h0, 4'h3, 1, 1'b0, 1'b1, 32'hA5A5A5A5, 2'b10};
        vecs[3] = '{30'h3FFFFFFF, 1'b0, 32'hFFFFFFFF, 32'h0BADF00D, 4'hC, 3, 1'b1, 1'b1, 32'h0BADF00D, 2'b10};
        vecs[4] = '{30'h055, 1'b1, 32'h01020304, 32'h0, 4'h1, 7, 1'b1, 1'b0, 32'h01020304, 2'b01};
        vecs[5] = '{30'h000, 1'b0, 32'hCCCCCCCC, 32'h0, 4'h0, 4, 1'b1, 1'b0, 32'h0, 2'b01};
        vecs[6] = '{30'h0AB, 1'b0, 32'h87654321, 32'hFFFFFFFF, 4'h5, 8, 1'b0, 1'b0, 32'h0, 2'b11};

        reset = 1'b1;
        wb_adr = '0; wb_dat_w = '0; wb_dat_r = '0; wb_sel = '0;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_ack = 1'b0; wb_err = 1'b0;
        rd_en = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clk48);
        check_zero_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            bus_txn(vecs[i].adr, vecs[i].we, vecs[i].dw, vecs[i].dr, vecs[i].sel,
                    vecs[i].waits, vecs[i].ack, vecs[i].err);
            if (vecs[i].exp_status == 2'b11) model_to = 1'b1;
            expect_push('{vecs[i].adr, vecs[i].exp_data, vecs[i].sel, vecs[i].we, vecs[i].exp_status});
            check_state($sformatf("vec%0d", i));
            drain($sformatf("vec%0d", i));
        end

        do_clr("clr1");

        // Zero-wait read: entry visible the cycle after the ack
        @(negedge clk48);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 30'h004;
        wb_dat_r = 32'h12345678; wb_sel = 4'hF; wb_ack = 1'b1;
        check("lat.ack_cycle.rd_valid", 64'(rd_valid), 64'd0);
        @(negedge clk48);
        check("lat.next_cycle.rd_valid", 64'(rd_valid), 64'd1);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_ack = 1'b0;
        expect_push('{30'h004, 32'h12345678, 4'hF, 1'b0, 2'b01});
        drain("lat");

        // Back-to-back: strobe held with ack on two consecutive cycles
        @(negedge clk48);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_ack = 1'b1;
        wb_adr = 30'h010; wb_dat_r = 32'h00000010; wb_sel = 4'hF;
        @(negedge clk48);
        wb_adr = 30'h011; wb_dat_r = 32'h00000011;
        @(negedge clk48);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_ack = 1'b0;
        expect_push('{30'h010, 32'h00000010, 4'hF, 1'b0, 2'b01});
        expect_push('{30'h011, 32'h00000011, 4'hF, 1'b0, 2'b01});
        check_state("b2b");
        drain("b2b");

        // Abandoned cycle and rd_en on an empty FIFO record nothing
        bus_txn(30'h020, 1'b1, 32'h1, 32'h0, 4'hF, 3, 1'b0, 1'b0);
        @(negedge clk48);
        rd_en = 1'b1;
        @(negedge clk48);
        rd_en = 1'b0;
        check_state("abandon");
        bus_txn(30'h021, 1'b1, 32'h21, 32'h0, 4'hF, 0, 1'b1, 1'b0);
        expect_push('{30'h021, 32'h21, 4'hF, 1'b1, 2'b01});
        drain("after_empty_rd");

        // Watchdog expiry on the 8th strobe cycle, then HOLD ignores ack until strobe drops
        do_clr("clr2");
        @(negedge clk48);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 30'h1234;
        wb_dat_w = 32'hCAFEF00D; wb_dat_r = 32'h5555; wb_sel = 4'h6; wb_ack = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk48);
            wb_ack = (i == 12);
            if (i == 7) check("tmo.cycle7.fifo_count", 64'(fifo_count), 64'd0);
            if (i == 8) begin
                model_to = 1'b1;
                expect_push('{30'h1234, 32'hCAFEF00D, 4'h6, 1'b1, 2'b11});
                check_state("tmo.cycle8");
            end
            if (i == 20) check_state("tmo.hold");
        end
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_ack = 1'b0;
        bus_txn(30'h008, 1'b0, 32'h0, 32'h600DF00D, 4'hF, 1, 1'b1, 1'b0);
        expect_push('{30'h008, 32'h600DF00D, 4'hF, 1'b0, 2'b01});
        check_state("tmo.after");
        drain("tmo");

        // clr coinciding with a push: txn_count reads 1
        do_clr("clr3");
        @(negedge clk48);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 30'h030;
        wb_dat_w = 32'h30303030; wb_sel = 4'hF; wb_ack = 1'b1; clr = 1'b1;
        @(negedge clk48);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_ack = 1'b0; clr = 1'b0;
        expect_push('{30'h030, 32'h30303030, 4'hF, 1'b1, 2'b01});
        check_state("clr_evt");
        drain("clr_evt");

        // Overflow: six pushes into a four-deep FIFO
        do_clr("clr4");
        for (int i = 0; i < 6; i++) begin
            bus_txn(30'(i + 64), 1'b1, 32'(i) * 32'h11111111, 32'h0, 4'hF, 0, 1'b1, 1'b0);
            expect_push('{30'(i + 64), 32'(i) * 32'h11111111, 4'hF, 1'b1, 2'b01});
        end
        check_state("ovf");
        drain("ovf");

        // Full FIFO with push and pop in the same cycle
        do_clr("clr5");
        for (int i = 0; i < 4; i++) begin
            bus_txn(30'(i + 80), 1'b0, 32'h0, 32'hA0 + 32'(i), 4'hF, 1, 1'b1, 1'b0);
            expect_push('{30'(i + 80), 32'hA0 + 32'(i), 4'hF, 1'b0, 2'b01});
        end
        check_state("full");
        @(negedge clk48);
        e = sb.pop_front();
        check_head("full_pp.head", e);
        model_count--;
        rd_en = 1'b1;
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 30'h077;
        wb_dat_w = 32'h77777777; wb_sel = 4'hF; wb_ack = 1'b1;
        @(negedge clk48);
        rd_en = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0; wb_ack = 1'b0;
        expect_push('{30'h077, 32'h77777777, 4'hF, 1'b1, 2'b01});
        check_state("full_pp");
        drain("full_pp");

        // Reset while waiting with two entries queued
        for (int i = 0; i < 2; i++) begin
            bus_txn(30'(i + 90), 1'b1, 32'h90 + 32'(i), 32'h0, 4'hF, 0, 1'b1, 1'b0);
            expect_push('{30'(i + 90), 32'h90 + 32'(i), 4'hF, 1'b1, 2'b01});
        end
        check_state("pre_rst");
        @(negedge clk48);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 30'h099;
        wb_dat_r = 32'h99999999; wb_sel = 4'hF; wb_ack = 1'b0;
        repeat (2) @(negedge clk48);
        #2 reset = 1'b1;
        #1 check_zero_outputs("rst_mid");
        sb.delete();
        model_count = 0; model_txn = 0; model_drop = 0; model_ovf = 1'b0; model_to = 1'b0;
        @(negedge clk48);
        reset = 1'b0;
        repeat (2) @(negedge clk48);
        wb_ack = 1'b1;
        @(negedge clk48);
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_ack = 1'b0;
        expect_push('{30'h099, 32'h99999999, 4'hF, 1'b0, 2'b01});
        check_state("post_rst");
        drain("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
